// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/timeout sequencer for the alarm clock.
// Outputs are registered, so they change the cycle after the decision that causes them.
module alarm_sequencer #(
  parameter int SNOOZE_SECS       = 300,
  parameter int RING_TIMEOUT_SECS = 60,
  parameter int MAX_SNOOZES       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_armed,
  input  logic       adjust,
  input  logic       match,
  input  logic [5:0] secs,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic [9:0] snooze_remaining,
  output logic [1:0] snoozes_used
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RINGING,
    S_SNOOZE,
    S_DONE
  } state_t;

  localparam logic [9:0] SNOOZE_INIT = 10'(SNOOZE_SECS);
  localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_SECS - 1);
  localparam logic [1:0] MAX_USED    = 2'(MAX_SNOOZES);

  state_t     r_state,      w_state_nxt;
  logic [7:0] r_ring_cnt,   w_ring_cnt_nxt;
  logic       r_phase,      w_phase_nxt;
  logic [9:0] r_snooze_rem, w_snooze_rem_nxt;
  logic [1:0] r_snoozes,    w_snoozes_nxt;
  logic       r_ringing;
  logic       r_snoozing;
  logic       r_buzzer;
  logic       w_can_snooze;
  logic       w_trigger;

  assign w_can_snooze = (r_snoozes < MAX_USED);
  assign w_trigger    = match && (secs == 6'd0) && !adjust;

  always_comb begin
    // NOTE: every next-state signal defaults to "hold" before the case, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt      = r_state;
    w_ring_cnt_nxt   = r_ring_cnt;
    w_phase_nxt      = r_phase;
    w_snooze_rem_nxt = r_snooze_rem;
    w_snoozes_nxt    = r_snoozes;

    if (!alarm_armed) begin
      w_state_nxt      = S_DONE;
      w_ring_cnt_nxt   = 8'd0;
      w_phase_nxt      = 1'b0;
      w_snooze_rem_nxt = 10'd0;
      w_snoozes_nxt    = 2'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            w_state_nxt    = S_RINGING;
            w_ring_cnt_nxt = 8'd0;
            w_phase_nxt    = 1'b1;
            w_snoozes_nxt  = 2'd0;
          end
        end
        S_RINGING: begin
          // Stop beats snooze, snooze beats timeout.
          if (btn_stop) begin
            w_state_nxt = S_DONE;
          end else if (btn_snooze && w_can_snooze) begin
            w_state_nxt      = S_SNOOZE;
            w_snooze_rem_nxt = SNOOZE_INIT;
            w_snoozes_nxt    = r_snoozes + 2'd1;
          end else if (tick_1hz) begin
            if (r_ring_cnt == RING_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_ring_cnt_nxt = r_ring_cnt + 8'd1;
              w_phase_nxt    = ~r_phase;
            end
          end
        end
        S_SNOOZE: begin
          if (btn_stop) begin
            w_state_nxt      = S_DONE;
            w_snooze_rem_nxt = 10'd0;
          end else if (tick_1hz) begin
            // <=1 rather than ==1 keeps the countdown from ever wrapping below zero.
            if (r_snooze_rem <= 10'd1) begin
              w_state_nxt      = S_RINGING;
              w_snooze_rem_nxt = 10'd0;
              w_ring_cnt_nxt   = 8'd0;
              w_phase_nxt      = 1'b1;
            end else begin
              w_snooze_rem_nxt = r_snooze_rem - 10'd1;
            end
          end
        end
        S_DONE: begin
          if (!match) begin
            w_state_nxt   = S_IDLE;
            w_snoozes_nxt = 2'd0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ring_cnt   <= 8'd0;
      r_phase      <= 1'b0;
      r_snooze_rem <= 10'd0;
      r_snoozes    <= 2'd0;
      r_ringing    <= 1'b0;
      r_snoozing   <= 1'b0;
      r_buzzer     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_snooze_rem <= w_snooze_rem_nxt;
      r_snoozes    <= w_snoozes_nxt;
      r_ringing    <= (w_state_nxt == S_RINGING);
      r_snoozing   <= (w_state_nxt == S_SNOOZE);
      r_buzzer     <= (w_state_nxt == S_RINGING) && w_phase_nxt;
    end
  end

  assign ringing          = r_ringing;
  assign snoozing         = r_snoozing;
  assign buzzer           = r_buzzer;
  assign snooze_remaining = r_snooze_rem;
  assign snoozes_used     = r_snoozes;

endmodule
